// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline and a word-organised data memory port.
// Aligned accesses take one memory cycle; misaligned ones use word reads and read-modify-write.
module dmem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_split,
  output logic        mem_W_en,
  output logic        mem_R_en,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_RW_type,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, ACC, RD0, RD1, WR0, WR1, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  type_q;
  logic [31:0] wdata_q;
  logic        split_q;
  logic [31:0] lo;
  logic [31:0] hi;

  logic        req_split;
  logic [31:0] w0;
  logic [31:0] w1;
  logic [5:0]  sh;
  logic [63:0] rd_cat;
  logic [31:0] load_val;
  logic [63:0] mask64;
  logic [63:0] data64;
  logic [63:0] merged;

  assign req_split = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                     (req_type[1] && (req_addr[1:0] != 2'b00));

  assign w0 = {addr_q[31:2], 2'b00};
  assign w1 = w0 + 32'd4;
  assign sh = {addr_q[1:0], 3'b000};

  // Split load: the high word is still on mem_dout during RD1, so it is used directly.
  assign rd_cat = {mem_dout, lo} >> sh;

  always_comb begin
    load_val = rd_cat[31:0];
    if (!type_q[1]) begin
      load_val = type_q[2] ? {16'h0000, rd_cat[15:0]}
                           : {{16{rd_cat[15]}}, rd_cat[15:0]};
    end
  end

  assign mask64 = (type_q[1] ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF) << sh;
  assign data64 = {32'h0000_0000, wdata_q} << sh;
  assign merged = ({hi, lo} & ~mask64) | (data64 & mask64);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_split <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      type_q    <= '0;
      wdata_q   <= '0;
      split_q   <= 1'b0;
      lo        <= '0;
      hi        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            type_q    <= req_type;
            wdata_q   <= req_wdata;
            split_q   <= req_split;
            req_ready <= 1'b0;
            state     <= req_split ? RD0 : ACC;
          end
        end
        ACC: begin
          rsp_valid <= 1'b1;
          rsp_split <= split_q;
          rsp_rdata <= we_q ? '0 : mem_dout;
          state     <= DONE;
        end
        RD0: begin
          lo    <= mem_dout;
          state <= RD1;
        end
        RD1: begin
          hi <= mem_dout;
          if (we_q) begin
            state <= WR0;
          end else begin
            rsp_valid <= 1'b1;
            rsp_split <= split_q;
            rsp_rdata <= load_val;
            state     <= DONE;
          end
        end
        WR0: state <= WR1;
        WR1: begin
          rsp_valid <= 1'b1;
          rsp_split <= split_q;
          rsp_rdata <= '0;
          state     <= DONE;
        end
        DONE: begin
          rsp_valid <= 1'b0;
          rsp_split <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_W_en    = 1'b0;
    mem_R_en    = 1'b0;
    mem_addr    = '0;
    mem_RW_type = '0;
    mem_din     = '0;
    case (state)
      ACC: begin
        mem_addr    = addr_q;
        mem_RW_type = type_q;
        mem_din     = wdata_q;
        mem_W_en    = we_q;
        mem_R_en    = !we_q;
      end
      RD0: begin
        mem_addr    = w0;
        mem_RW_type = 3'b010;
        mem_R_en    = 1'b1;
      end
      RD1: begin
        mem_addr    = w1;
        mem_RW_type = 3'b010;
        mem_R_en    = 1'b1;
      end
      WR0: begin
        mem_addr    = w0;
        mem_RW_type = 3'b010;
        mem_din     = merged[31:0];
        mem_W_en    = 1'b1;
      end
      WR1: begin
        mem_addr    = w1;
        mem_RW_type = 3'b010;
        mem_din     = merged[63:32];
        mem_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port req_valid, input, 1 bit: the pipeline presents a load/store request.
REQ-004 The block SHALL have the port req_ready, output, 1 bit: a request is accepted in a cycle where req_valid and req_ready are both 1.
REQ-005 The block SHALL have the ports req_we (input, 1: 1=store), req_addr (input, 32: byte address), req_type (input, 3) and req_wdata (input, 32: store data, right-justified).
REQ-006 req_type SHALL be encoded as follows: [1:0] 00=byte, 01=half, 10=word, 11=word; [2]=1 unsigned load; [2] is ignored for stores and for word accesses.
REQ-007 The block SHALL have the ports rsp_valid (output, 1: one-cycle completion pulse), rsp_rdata (output, 32: load result) and rsp_split (output, 1: the access was split).
REQ-008 The block SHALL have the ports mem_W_en, mem_R_en (outputs, 1), mem_addr (output, 32), mem_RW_type (output, 3), mem_din (output, 32) and mem_dout (input, 32), all driving the data-memory port.
REQ-009 The memory port SHALL have this contract: mem_dout is combinational from mem_addr/mem_RW_type in the same cycle; a write commits at the rising edge while mem_W_en=1; memory performs byte/half lane placement and extension for aligned sub-word types.

Function
REQ-010 The FSM SHALL have the states IDLE, ACC, RD0, RD1, WR0, WR1 and DONE; req_ready=1 only in IDLE.
REQ-011 On acceptance the block SHALL latch we, addr, type and wdata, and classify the access: byte at any offset, half with addr[0]=0, or word with addr[1:0]=00 is aligned; everything else is split.
REQ-012 An aligned access SHALL follow IDLE->ACC->DONE; in ACC: mem_addr=latched addr, mem_RW_type=latched type, mem_din=wdata, and R_en or W_en asserted per we.
REQ-013 In ACC for an aligned load, mem_dout SHALL be registered unchanged as the result.
REQ-014 A split load SHALL follow IDLE->RD0->RD1->DONE, with W0={addr[31:2],2'b00} and W1=W0+4 modulo 2^32, both read with mem_RW_type=3'b010 and R_en=1.
REQ-015 For a split load the results of both reads SHALL be latched as lo and hi; result = ({hi,lo} >> 8*addr[1:0]) truncated to 16 or 32 bits; a half is zero-extended if type[2]=1, else sign-extended.
REQ-016 A split store SHALL follow IDLE->RD0->RD1->WR0->WR1->DONE, with reads as in REQ-014.
REQ-017 In WR0/WR1 of a split store the block SHALL write W0/W1 with type 3'b010 and W_en=1, where data = lo/hi with the bytes addressed by the access replaced by the corresponding bytes of wdata (2 bytes for half, 4 for word); untouched bytes are preserved.
REQ-018 DONE SHALL last one cycle with rsp_valid=1, rsp_split=classification, and rsp_rdata=result for loads or 0 for stores, then go to IDLE.
REQ-019 Latency from the acceptance edge to rsp_valid SHALL be: aligned 2 cycles, split load 3, split store 5; the next request can be accepted in the cycle after DONE.
REQ-020 Outside ACC/RDx/WRx the block SHALL hold mem_W_en=0, mem_R_en=0, mem_addr=0, mem_RW_type=0 and mem_din=0; W_en and R_en are never both 1.
REQ-021 All mem_* outputs SHALL be decoded combinationally from registered state only, with no path from req_* to mem_*.
REQ-022 req_* inputs SHALL be ignored outside IDLE.
REQ-023 A request with addr 0xFFFFFFFD..0xFFFFFFFF that is split SHALL access W1=0x00000000.

Reset
REQ-024 While rst_n=0 the block SHALL hold state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_split=0, all mem_* outputs=0, and latched request/lo/hi=0.
REQ-025 A reset asserted mid-transaction SHALL drop mem_W_en immediately (asynchronously), perform no further memory write, produce no rsp_valid for the aborted request, and leave any already-committed WR0 write in place.

Verification
REQ-026 The bench SHALL cover: mem[0x100]=0x11223344, load word 0x100 -> one R_en cycle at addr 0x100 with type 010; rsp_valid at T+2 with rdata 0x11223344 and split=0.
REQ-027 The bench SHALL cover: signed byte load at 0x103 -> ACC cycle with addr 0x103 and type 000; rsp_rdata equals mem_dout from that cycle; split=0.
REQ-028 The bench SHALL cover: mem[0x100]=0xAABBCCDD, mem[0x104]=0x11223384, signed half load at 0x103 -> reads at 0x100 then 0x104, rdata 0xFFFF84AA at T+3; the unsigned variant gives 0x000084AA; split=1.
REQ-029 The bench SHALL cover: mem[0x100]=0x00000000, mem[0x104]=0xFFFFFFFF, word store 0xDEADBEEF at 0x102 -> sequence R,R,W,W; mem[0x100]=0xBEEF0000, mem[0x104]=0xFFFFDEAD; rsp_valid at T+5.
REQ-030 The bench SHALL cover: word load at 0xFFFFFFFE -> RD0 at addr 0xFFFFFFFC, RD1 at addr 0x00000000.
REQ-031 The bench SHALL cover: rst_n pulled low during the WR0 cycle of the REQ-029 store -> mem_W_en falls before the edge, mem[0x104] is unchanged, no rsp_valid occurs, and req_ready=1 after reset release.
